mel_frame_sequencer: RTL and testbench
======================================

// Module: mel_frame_sequencer
// PURPOSE
//  Sequences FFT power-bin frames into mel_filter. Accepts bins on a valid/ready stream and
//  drives mel_filter's di_en, in_group_idx (0..BINS-1), in_group_num, is_first_in, is_last_in.
//  Holds off the next frame until mel_filter reports do_en for the current one.
//  Sits between the FFT magnitude stage and mel_filter; one instance per mel_filter.
// PARAMETERS
//  I_BW        14    bin sample width (matches mel_filter I_BW)
//  BINS        513   bins per frame; in_group_idx wraps at BINS-1
//  FRAMES      64    frames per run; in_group_num counts 0..FRAMES-1
//  TIMEOUT_CYC 1024  max cycles in WAIT_OUT before timeout (MEL_SEQ_TIMEOUT_EN only)
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      asynchronous reset, active-low
//  start            in   1      1-cycle pulse; starts a run of FRAMES frames (IDLE only)
//  s_data           in   I_BW   signed bin sample from upstream
//  s_valid          in   1      s_data valid
//  s_ready          out  1      sequencer accepts s_data this cycle
//  mf_data          out  I_BW   signed sample to mel_filter data_i
//  mf_di_en         out  1      mel_filter di_en
//  mf_group_idx     out  10     mel_filter in_group_idx
//  mf_group_num     out  7      mel_filter in_group_num
//  mf_is_first      out  1      mel_filter is_first_in (idx==0)
//  mf_is_last       out  1      mel_filter is_last_in (idx==BINS-1)
//  mf_do_en         in   1      mel_filter do_en
//  mf_out_group_num in   7      mel_filter out_group_num
//  busy             out  1      high in STREAM/WAIT_OUT
//  done             out  1      1-cycle pulse after last frame's do_en
//  err_seq          out  1      sticky: do_en seen with out_group_num != current frame
//  err_timeout      out  1      sticky: WAIT_OUT exceeded TIMEOUT_CYC (macro only)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0; idx, frame, timer cleared. Mid-run reset aborts cleanly.
//  States: IDLE -start-> STREAM -last bin accepted-> WAIT_OUT -do_en match->
//    STREAM (frame+1) or DONE if frame==FRAMES-1; DONE -> IDLE after 1 cycle (done=1 there).
//  start outside IDLE ignored. s_ready = (state==STREAM), combinational from state only.
//  Accept = s_valid & s_ready. On accept: next edge registers mf_data=s_data, mf_di_en=1,
//    mf_group_idx=idx, mf_group_num=frame, first/last flags; idx++ (wraps to 0 after BINS-1).
//  Latency s_data -> mf_data: exactly 1 cycle. No accept -> mf_di_en=0, other mf_* hold.
//  s_valid gaps allowed; idx does not advance without accept.
//  Accept of idx BINS-1 moves to WAIT_OUT same edge; s_ready drops next cycle.
//  WAIT_OUT: advance only on mf_do_en & mf_out_group_num==frame; mismatch sets err_seq, stay.
//  do_en outside WAIT_OUT ignored. err_* cleared only by reset.
// CONFIGURATION
//  MEL_SEQ_TIMEOUT_EN defined: 11-bit timer counts in WAIT_OUT; reaching TIMEOUT_CYC sets
//    err_timeout, FSM -> IDLE (busy=0, no done pulse). Timer clears on entry to WAIT_OUT.
//  Not defined: no timer; WAIT_OUT waits indefinitely; err_timeout tied 0.
// STRUCTURE
//  mel_seq_pkg: state encoding (IDLE/STREAM/WAIT_OUT/DONE), default BINS/FRAMES, IDX_BW=10, NUM_BW=7.
//  Sub-module mel_bin_counter: idx/frame counter pair with wrap and last-bin/last-frame flags.
// TESTING
//  start, s_valid=1 every cycle, s_data=1000, FRAMES=2 -> mf_di_en 513 cycles, idx 0..512,
//    is_first at idx0, is_last at idx512, s_ready low from next cycle until do_en(num=0).
//  do_en with out_group_num=0 in WAIT_OUT -> STREAM, next mf_group_num=1; after frame 1 do_en -> done=1 one cycle, busy=0.
//  s_valid toggling 1,0,1,0 -> mf_di_en mirrors accepts one cycle later; idx increments only on accepts.
//  do_en with out_group_num=5 while frame=0 -> err_seq=1, state stays WAIT_OUT.
//  rst=0 mid-frame at idx 200 -> all outputs 0 immediately; after release start -> idx restarts 0, frame 0.
//  MEL_SEQ_TIMEOUT_EN, no do_en for 1024 cycles -> err_timeout=1, busy=0, no done; start ignored while busy.

Source files
------------

// File: rtl/mel_seq_pkg.sv
// Shared types and widths for the mel_filter frame sequencer.
// Optional WAIT_OUT timeout is enabled with `define MEL_SEQ_TIMEOUT_EN.
package mel_seq_pkg;

  localparam int IDX_BW     = 10;
  localparam int NUM_BW     = 7;
  localparam int TMR_BW     = 11;
  localparam int DEF_BINS   = 513;
  localparam int DEF_FRAMES = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_e;

  function automatic logic is_busy(input seq_state_e s);
    return (s == ST_STREAM) || (s == ST_WAIT_OUT);
  endfunction

endpackage

// File: rtl/mel_bin_counter.sv
// Bin index / frame number counter pair with wrap and last-bin/last-frame flags.
module mel_bin_counter
  import mel_seq_pkg::*;
#(
  parameter int BINS   = DEF_BINS,
  parameter int FRAMES = DEF_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              bin_adv,
  input  logic              frame_adv,
  output logic [IDX_BW-1:0] idx,
  output logic [NUM_BW-1:0] frame,
  output logic              last_bin,
  output logic              last_frame
);

  logic [IDX_BW-1:0] idx_q, idx_d;
  logic [NUM_BW-1:0] frame_q, frame_d;

  assign last_bin   = (idx_q == IDX_BW'(BINS - 1));
  assign last_frame = (frame_q == NUM_BW'(FRAMES - 1));
  assign idx        = idx_q;
  assign frame      = frame_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    idx_d   = idx_q;
    frame_d = frame_q;
    if (clear) begin
      idx_d   = '0;
      frame_d = '0;
    end else begin
      if (bin_adv)   idx_d   = last_bin   ? '0 : idx_q + 1'b1;
      if (frame_adv) frame_d = last_frame ? '0 : frame_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/mel_frame_sequencer.sv
// Feeds FFT power-bin frames into mel_filter, one frame at a time, gated by do_en.
// Optional WAIT_OUT timeout is enabled with `define MEL_SEQ_TIMEOUT_EN.
module mel_frame_sequencer
  import mel_seq_pkg::*;
#(
  parameter int I_BW        = 14,
  parameter int BINS        = DEF_BINS,
  parameter int FRAMES      = DEF_FRAMES,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [I_BW-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic signed [I_BW-1:0] mf_data,
  output logic                   mf_di_en,
  output logic [IDX_BW-1:0]      mf_group_idx,
  output logic [NUM_BW-1:0]      mf_group_num,
  output logic                   mf_is_first,
  output logic                   mf_is_last,
  input  logic                   mf_do_en,
  input  logic [NUM_BW-1:0]      mf_out_group_num,
  output logic                   busy,
  output logic                   done,
  output logic                   err_seq,
  output logic                   err_timeout
);

  seq_state_e state_q, state_d;
  logic err_seq_q, err_seq_d;

  logic signed [I_BW-1:0] mf_data_q, mf_data_d;
  logic                   mf_di_en_q, mf_di_en_d;
  logic [IDX_BW-1:0]      mf_group_idx_q, mf_group_idx_d;
  logic [NUM_BW-1:0]      mf_group_num_q, mf_group_num_d;
  logic                   mf_is_first_q, mf_is_first_d;
  logic                   mf_is_last_q, mf_is_last_d;

  logic              accept, cnt_clear, frame_adv;
  logic [IDX_BW-1:0] idx;
  logic [NUM_BW-1:0] frame;
  logic              last_bin, last_frame;

`ifdef MEL_SEQ_TIMEOUT_EN
  logic [TMR_BW-1:0] timer_q, timer_d;
  logic              err_timeout_q, err_timeout_d;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  assign s_ready = (state_q == ST_STREAM);
  assign accept  = s_valid & s_ready;
  assign busy    = is_busy(state_q);
  assign done    = (state_q == ST_DONE);
  assign err_seq = err_seq_q;

  mel_bin_counter #(
    .BINS   (BINS),
    .FRAMES (FRAMES)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .bin_adv    (accept),
    .frame_adv  (frame_adv),
    .idx        (idx),
    .frame      (frame),
    .last_bin   (last_bin),
    .last_frame (last_frame)
  );

  always_comb begin
    state_d   = state_q;
    err_seq_d = err_seq_q;
    cnt_clear = 1'b0;
    frame_adv = 1'b0;
`ifdef MEL_SEQ_TIMEOUT_EN
    timer_d       = timer_q;
    err_timeout_d = err_timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_STREAM;
          cnt_clear = 1'b1;
        end
      end
      ST_STREAM: begin
        if (accept && last_bin) begin
          state_d = ST_WAIT_OUT;
`ifdef MEL_SEQ_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      ST_WAIT_OUT: begin
        // A matching do_en wins over a timeout expiring in the same cycle.
        if (mf_do_en && (mf_out_group_num == frame)) begin
          frame_adv = 1'b1;
          state_d   = last_frame ? ST_DONE : ST_STREAM;
        end else begin
          if (mf_do_en) err_seq_d = 1'b1;
`ifdef MEL_SEQ_TIMEOUT_EN
          timer_d = timer_q + 1'b1;
          if (timer_q == TMR_BW'(TIMEOUT_CYC - 1)) begin
            err_timeout_d = 1'b1;
            state_d       = ST_IDLE;
          end
`endif
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mf_di_en_d     = accept;
    mf_data_d      = mf_data_q;
    mf_group_idx_d = mf_group_idx_q;
    mf_group_num_d = mf_group_num_q;
    mf_is_first_d  = mf_is_first_q;
    mf_is_last_d   = mf_is_last_q;
    if (accept) begin
      mf_data_d      = s_data;
      mf_group_idx_d = idx;
      mf_group_num_d = frame;
      mf_is_first_d  = (idx == '0);
      mf_is_last_d   = last_bin;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      err_seq_q      <= 1'b0;
      mf_data_q      <= '0;
      mf_di_en_q     <= 1'b0;
      mf_group_idx_q <= '0;
      mf_group_num_q <= '0;
      mf_is_first_q  <= 1'b0;
      mf_is_last_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_seq_q      <= err_seq_d;
      mf_data_q      <= mf_data_d;
      mf_di_en_q     <= mf_di_en_d;
      mf_group_idx_q <= mf_group_idx_d;
      mf_group_num_q <= mf_group_num_d;
      mf_is_first_q  <= mf_is_first_d;
      mf_is_last_q   <= mf_is_last_d;
    end
  end

`ifdef MEL_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
    end
  end
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign mf_data      = mf_data_q;
  assign mf_di_en     = mf_di_en_q;
  assign mf_group_idx = mf_group_idx_q;
  assign mf_group_num = mf_group_num_q;
  assign mf_is_first  = mf_is_first_q;
  assign mf_is_last   = mf_is_last_q;

endmodule

// File: tb/tb_mel_frame_sequencer.sv
// Directed scoreboard bench for mel_frame_sequencer (BINS=513, FRAMES=2).
// Build with `define MEL_SEQ_TIMEOUT_EN to also exercise the WAIT_OUT timeout.
module tb_mel_frame_sequencer;

  localparam int BINS   = 513;
  localparam int FRAMES = 2;

  typedef struct packed {
    logic [13:0] data;
    logic [9:0]  idx;
    logic [6:0]  num;
    logic        first;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [13:0] mf_data;
  logic        mf_di_en;
  logic [9:0]  mf_group_idx;
  logic [6:0]  mf_group_num;
  logic        mf_is_first;
  logic        mf_is_last;
  logic        mf_do_en = 1'b0;
  logic [6:0]  mf_out_group_num = '0;
  logic        busy, done, err_seq, err_timeout;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t sb[$];
  beat_t got[$];

  mel_frame_sequencer #(
    .I_BW        (14),
    .BINS        (BINS),
    .FRAMES      (FRAMES),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .mf_data          (mf_data),
    .mf_di_en         (mf_di_en),
    .mf_group_idx     (mf_group_idx),
    .mf_group_num     (mf_group_num),
    .mf_is_first      (mf_is_first),
    .mf_is_last       (mf_is_last),
    .mf_do_en         (mf_do_en),
    .mf_out_group_num (mf_out_group_num),
    .busy             (busy),
    .done             (done),
    .err_seq          (err_seq),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  // Capture every mel_filter input beat away from the active edge.
  always @(negedge clk) begin
    if (rst && mf_di_en)
      got.push_back('{data: mf_data, idx: mf_group_idx, num: mf_group_num,
                      first: mf_is_first, last: mf_is_last});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bin(input int idx, input int frame, input logic [13:0] d);
    s_valid = 1'b1;
    s_data  = d;
    check("s_ready_stream", 64'(s_ready), 64'd1);
    sb.push_back('{data: d, idx: 10'(idx), num: 7'(frame),
                   first: (idx == 0), last: (idx == BINS - 1)});
    tick();
    s_valid = 1'b0;
  endtask

  // mode 0: constant 1000; mode 1: random data; mode 2: random data with 1,0,1,0 valid early on
  task automatic send_range(input int frame, input int lo, input int hi, input int mode);
    logic [13:0] d;
    for (int i = lo; i <= hi; i++) begin
      d = (mode == 0) ? 14'd1000 : 14'($urandom);
      send_bin(i, frame, d);
      if (mode == 2 && i < 8) begin
        s_valid = 1'b0;
        s_data  = 14'($urandom);
        tick();
        if (i == 2) begin
          check("gap_di_en_low", 64'(mf_di_en), 64'd0);
          check("gap_idx_hold", 64'(mf_group_idx), 64'd2);
          check("gap_data_hold", 64'(mf_data), 64'(d));
        end
      end
    end
  endtask

  // Let the last registered beat be captured, then compare the scoreboard in order.
  task automatic drain();
    beat_t e, o;
    s_valid = 1'b0;
    tick();
    tick();
    check("beat_count", 64'(got.size()), 64'(sb.size()));
    while (sb.size() > 0 && got.size() > 0) begin
      e = sb.pop_front();
      o = got.pop_front();
      check($sformatf("beat_idx%0d_num%0d", e.idx, e.num), 64'(o), 64'(e));
    end
    sb.delete();
    got.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_do_en(input logic [6:0] num);
    mf_do_en         = 1'b1;
    mf_out_group_num = num;
    tick();
    mf_do_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_di_en", 64'(mf_di_en), 64'd0);
    check("rst_mf_fields", 64'({mf_data, mf_group_idx, mf_group_num, mf_is_first, mf_is_last}), 64'd0);
    check("rst_errs", 64'({err_seq, err_timeout}), 64'd0);
    rst = 1'b1;
    tick();

    // Frame 0, continuous valid, with a stray do_en during STREAM
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    send_range(0, 0, 99, 0);
    s_valid = 1'b0;
    pulse_do_en(7'd0);
    check("stream_do_en_ignored", 64'(s_ready), 64'd1);
    send_range(0, 100, BINS - 1, 0);
    check("wait_s_ready_low", 64'(s_ready), 64'd0);
    check("wait_busy", 64'(busy), 64'd1);
    s_valid = 1'b1;
    drain();

    // start ignored while busy, wrong-frame do_en flags err_seq
    pulse_start();
    check("start_ignored_busy", 64'({busy, s_ready}), 64'b10);
    pulse_do_en(7'd5);
    check("err_seq_set", 64'(err_seq), 64'd1);
    check("err_seq_stay_wait", 64'({busy, s_ready}), 64'b10);
    pulse_do_en(7'd0);
    check("match_to_stream", 64'(s_ready), 64'd1);
    check("err_seq_sticky", 64'(err_seq), 64'd1);

    // Frame 1 with valid gaps, then final do_en produces done
    send_range(1, 0, BINS - 1, 2);
    drain();
    pulse_do_en(7'd1);
    check("done_pulse", 64'({done, busy, s_ready}), 64'b100);
    tick();
    check("done_one_cycle", 64'({done, busy}), 64'b00);

`ifdef MEL_SEQ_TIMEOUT_EN
    // No do_en: timeout after 1024 cycles in WAIT_OUT, no done pulse
    pulse_start();
    send_range(0, 0, BINS - 1, 1);
    repeat (1022) tick();
    pulse_start();
    check("pre_timeout_busy", 64'({busy, err_timeout}), 64'b10);
    tick();
    check("timeout_state", 64'({busy, err_timeout, done, s_ready}), 64'b0100);
    tick();
    check("timeout_no_done", 64'({done, busy}), 64'b00);
    drain();
`else
    // No timer: WAIT_OUT holds indefinitely
    pulse_start();
    send_range(0, 0, BINS - 1, 1);
    repeat (200) tick();
    check("no_timeout_wait", 64'({busy, s_ready, err_timeout}), 64'b100);
    drain();
`endif

    // Mid-frame reset at idx 200 clears everything asynchronously
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pulse_start();
    send_range(0, 0, 200, 1);
    drain();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ctrl", 64'({busy, s_ready, done, mf_di_en}), 64'd0);
    check("midrst_mf_fields", 64'({mf_data, mf_group_idx, mf_group_num, mf_is_first, mf_is_last}), 64'd0);
    check("midrst_errs", 64'({err_seq, err_timeout}), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    pulse_start();
    send_range(0, 0, 4, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
